// File: rtl/pi1_to_axi4_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pi1_if / axi4_if                                                           |
// | PI1 word bus and single-beat AXI4 bus bundles used by pi1_to_axi4.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

interface pi1_if #(
   parameter int ARCHBITSZ = 32
) ();
   localparam int ADDRW = ARCHBITSZ - $clog2(ARCHBITSZ/8);

   logic [1:0]             pi1_op_i;
   logic [ADDRW-1:0]       pi1_addr_i;
   logic [ARCHBITSZ-1:0]   pi1_data_i;
   logic [ARCHBITSZ-1:0]   pi1_data_o;
   logic [ARCHBITSZ/8-1:0] pi1_sel_i;
   logic                   pi1_rdy_o;

   modport master (
      output pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
      input  pi1_data_o, pi1_rdy_o
   );

   modport slave (
      input  pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
      output pi1_data_o, pi1_rdy_o
   );
endinterface

interface axi4_if #(
   parameter int ARCHBITSZ     = 32,
   parameter int AXI4_ID_WIDTH = 4
) ();
   logic [AXI4_ID_WIDTH-1:0] axi4_awid_o;
   logic [ARCHBITSZ-1:0]     axi4_awaddr_o;
   logic [7:0]               axi4_awlen_o;
   logic [2:0]               axi4_awsize_o;
   logic [1:0]               axi4_awburst_o;
   logic [0:0]               axi4_awlock_o;
   logic [3:0]               axi4_awcache_o;
   logic [2:0]               axi4_awprot_o;
   logic [3:0]               axi4_awqos_o;
   logic                     axi4_awvalid_o;
   logic                     axi4_awready_i;

   logic [ARCHBITSZ-1:0]     axi4_wdata_o;
   logic [ARCHBITSZ/8-1:0]   axi4_wstrb_o;
   logic                     axi4_wlast_o;
   logic                     axi4_wvalid_o;
   logic                     axi4_wready_i;

   logic                     axi4_bready_o;
   logic [AXI4_ID_WIDTH-1:0] axi4_bid_i;
   logic [1:0]               axi4_bresp_i;
   logic                     axi4_bvalid_i;

   logic [AXI4_ID_WIDTH-1:0] axi4_arid_o;
   logic [ARCHBITSZ-1:0]     axi4_araddr_o;
   logic [7:0]               axi4_arlen_o;
   logic [2:0]               axi4_arsize_o;
   logic [1:0]               axi4_arburst_o;
   logic [0:0]               axi4_arlock_o;
   logic [3:0]               axi4_arcache_o;
   logic [2:0]               axi4_arprot_o;
   logic [3:0]               axi4_arqos_o;
   logic                     axi4_arvalid_o;
   logic                     axi4_arready_i;

   logic                     axi4_rready_o;
   logic [AXI4_ID_WIDTH-1:0] axi4_rid_i;
   logic [ARCHBITSZ-1:0]     axi4_rdata_i;
   logic [1:0]               axi4_rresp_i;
   logic                     axi4_rlast_i;
   logic                     axi4_rvalid_i;

   modport master (
      output axi4_awid_o, axi4_awaddr_o, axi4_awlen_o, axi4_awsize_o, axi4_awburst_o,
             axi4_awlock_o, axi4_awcache_o, axi4_awprot_o, axi4_awqos_o, axi4_awvalid_o,
             axi4_wdata_o, axi4_wstrb_o, axi4_wlast_o, axi4_wvalid_o, axi4_bready_o,
             axi4_arid_o, axi4_araddr_o, axi4_arlen_o, axi4_arsize_o, axi4_arburst_o,
             axi4_arlock_o, axi4_arcache_o, axi4_arprot_o, axi4_arqos_o, axi4_arvalid_o,
             axi4_rready_o,
      input  axi4_awready_i, axi4_wready_i, axi4_bid_i, axi4_bresp_i, axi4_bvalid_i,
             axi4_arready_i, axi4_rid_i, axi4_rdata_i, axi4_rresp_i, axi4_rlast_i,
             axi4_rvalid_i
   );

   modport slave (
      input  axi4_awid_o, axi4_awaddr_o, axi4_awlen_o, axi4_awsize_o, axi4_awburst_o,
             axi4_awlock_o, axi4_awcache_o, axi4_awprot_o, axi4_awqos_o, axi4_awvalid_o,
             axi4_wdata_o, axi4_wstrb_o, axi4_wlast_o, axi4_wvalid_o, axi4_bready_o,
             axi4_arid_o, axi4_araddr_o, axi4_arlen_o, axi4_arsize_o, axi4_arburst_o,
             axi4_arlock_o, axi4_arcache_o, axi4_arprot_o, axi4_arqos_o, axi4_arvalid_o,
             axi4_rready_o,
      output axi4_awready_i, axi4_wready_i, axi4_bid_i, axi4_bresp_i, axi4_bvalid_i,
             axi4_arready_i, axi4_rid_i, axi4_rdata_i, axi4_rresp_i, axi4_rlast_i,
             axi4_rvalid_i
   );
endinterface

`default_nettype wire

// File: rtl/pi1_to_axi4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pi1_to_axi4                                                                |
// | PI1 slave to AXI4 master bridge: single-word READ/WRITE/SWAP issued as     |
// | single-beat AXI4 transactions, one outstanding. Optional macro             |
// | PI1_TO_AXI4_ERR_EN adds err_o and skips the SWAP write on a read error.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module pi1_to_axi4 #(
   parameter int ARCHBITSZ     = 32,
   parameter int AXI4_ID_WIDTH = 4,
   parameter int AXI4_ID       = 0
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   pi1_if.slave   pi1,
   axi4_if.master axi4
`ifdef PI1_TO_AXI4_ERR_EN
   ,
   output logic   err_o
`endif
);

   localparam int ADDR_LSB = $clog2(ARCHBITSZ/8);
   localparam int ADDRW    = ARCHBITSZ - ADDR_LSB;
   localparam int SELW     = ARCHBITSZ/8;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SWAP  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW_W = 3'd3,
      ST_B    = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic [ADDRW-1:0]     addr_q, addr_d;
   logic [ARCHBITSZ-1:0] wdata_q, wdata_d;
   logic [SELW-1:0]      sel_q, sel_d;
   logic [ARCHBITSZ-1:0] rdata_q, rdata_d;
   logic                 rdy_q, rdy_d;
   logic                 arvalid_q, arvalid_d;
   logic                 rready_q, rready_d;
   logic                 awvalid_q, awvalid_d;
   logic                 wvalid_q, wvalid_d;
   logic                 bready_q, bready_d;
`ifdef PI1_TO_AXI4_ERR_EN
   logic                 err_q, err_d;
`endif

   logic accept;
   logic swap_wr;
   logic aw_ok;
   logic w_ok;
   logic unused_inputs;

   // New ops are taken both in IDLE and in DONE so back-to-back ops lose no cycle.
   assign accept = rdy_q && (pi1.pi1_op_i != OP_NOP) &&
                   ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef PI1_TO_AXI4_ERR_EN
   assign swap_wr = (op_q == OP_SWAP) && !axi4.axi4_rresp_i[1];
`else
   assign swap_wr = (op_q == OP_SWAP);
`endif

   assign aw_ok = !awvalid_q || axi4.axi4_awready_i;
   assign w_ok  = !wvalid_q  || axi4.axi4_wready_i;

   assign unused_inputs = ^{axi4.axi4_bid_i, axi4.axi4_rid_i, axi4.axi4_rlast_i,
                            axi4.axi4_rresp_i, axi4.axi4_bresp_i};

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      sel_d     = sel_q;
      rdata_d   = rdata_q;
      rdy_d     = rdy_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
`ifdef PI1_TO_AXI4_ERR_EN
      err_d     = err_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               op_d    = pi1.pi1_op_i;
               addr_d  = pi1.pi1_addr_i;
               wdata_d = pi1.pi1_data_i;
               sel_d   = pi1.pi1_sel_i;
               rdy_d   = 1'b0;
`ifdef PI1_TO_AXI4_ERR_EN
               err_d   = 1'b0;
`endif
               if (pi1.pi1_op_i == OP_WRITE) begin
                  state_d   = ST_AW_W;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = ST_AR;
                  arvalid_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_AR: begin
            if (axi4.axi4_arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_R;
            end
         end
         ST_R: begin
            if (axi4.axi4_rvalid_i) begin
               rdata_d  = axi4.axi4_rdata_i;
               rready_d = 1'b0;
               if (swap_wr) begin
                  state_d   = ST_AW_W;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d = ST_DONE;
                  rdy_d   = 1'b1;
`ifdef PI1_TO_AXI4_ERR_EN
                  err_d   = axi4.axi4_rresp_i[1];
`endif
               end
            end
         end
         ST_AW_W: begin
            // AW and W complete independently; move on once both have been accepted.
            if (awvalid_q && axi4.axi4_awready_i) awvalid_d = 1'b0;
            if (wvalid_q && axi4.axi4_wready_i)   wvalid_d  = 1'b0;
            if (aw_ok && w_ok) begin
               state_d  = ST_B;
               bready_d = 1'b1;
            end
         end
         ST_B: begin
            if (axi4.axi4_bvalid_i) begin
               bready_d = 1'b0;
               rdy_d    = 1'b1;
               state_d  = ST_DONE;
`ifdef PI1_TO_AXI4_ERR_EN
               err_d    = axi4.axi4_bresp_i[1];
`endif
            end
         end
         default: begin
            state_d   = ST_IDLE;
            rdy_d     = 1'b1;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_NOP;
         addr_q    <= '0;
         wdata_q   <= '0;
         sel_q     <= '0;
         rdata_q   <= '0;
         rdy_q     <= 1'b1;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
`ifdef PI1_TO_AXI4_ERR_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         sel_q     <= sel_d;
         rdata_q   <= rdata_d;
         rdy_q     <= rdy_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
`ifdef PI1_TO_AXI4_ERR_EN
         err_q     <= err_d;
`endif
      end
   end

   assign pi1.pi1_data_o = rdata_q;
   assign pi1.pi1_rdy_o  = rdy_q;
`ifdef PI1_TO_AXI4_ERR_EN
   assign err_o = err_q;
`endif

   assign axi4.axi4_awid_o    = AXI4_ID_WIDTH'(AXI4_ID);
   assign axi4.axi4_awaddr_o  = {addr_q, {ADDR_LSB{1'b0}}};
   assign axi4.axi4_awlen_o   = 8'd0;
   assign axi4.axi4_awsize_o  = 3'(ADDR_LSB);
   assign axi4.axi4_awburst_o = 2'b01;
   assign axi4.axi4_awlock_o  = 1'b0;
   assign axi4.axi4_awcache_o = 4'b0011;
   assign axi4.axi4_awprot_o  = 3'b000;
   assign axi4.axi4_awqos_o   = 4'd0;
   assign axi4.axi4_awvalid_o = awvalid_q;

   assign axi4.axi4_wdata_o   = wdata_q;
   assign axi4.axi4_wstrb_o   = sel_q;
   assign axi4.axi4_wlast_o   = 1'b1;
   assign axi4.axi4_wvalid_o  = wvalid_q;
   assign axi4.axi4_bready_o  = bready_q;

   assign axi4.axi4_arid_o    = AXI4_ID_WIDTH'(AXI4_ID);
   assign axi4.axi4_araddr_o  = {addr_q, {ADDR_LSB{1'b0}}};
   assign axi4.axi4_arlen_o   = 8'd0;
   assign axi4.axi4_arsize_o  = 3'(ADDR_LSB);
   assign axi4.axi4_arburst_o = 2'b01;
   assign axi4.axi4_arlock_o  = 1'b0;
   assign axi4.axi4_arcache_o = 4'b0011;
   assign axi4.axi4_arprot_o  = 3'b000;
   assign axi4.axi4_arqos_o   = 4'd0;
   assign axi4.axi4_arvalid_o = arvalid_q;
   assign axi4.axi4_rready_o  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_pi1_to_axi4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pi1_to_axi4                                                             |
// | Bench for pi1_to_axi4 with a small AXI4 memory slave with per-op delays.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_pi1_to_axi4;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_SWAP  = 2'b11;

   typedef struct {
      logic [1:0]  op;
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      int          ar_dly;
      int          r_dly;
      int          aw_dly;
      int          w_dly;
      int          b_dly;
      logic [31:0] exp_data;
      int          exp_lat;
      logic [31:0] exp_axaddr;
      logic [31:0] exp_mem;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pi1_if  #(.ARCHBITSZ(32))                      pi1 ();
   axi4_if #(.ARCHBITSZ(32), .AXI4_ID_WIDTH(4))   axi ();
`ifdef PI1_TO_AXI4_ERR_EN
   logic err;
`endif

   pi1_to_axi4 #(.ARCHBITSZ(32), .AXI4_ID_WIDTH(4), .AXI4_ID(0)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .pi1    (pi1),
      .axi4   (axi)
`ifdef PI1_TO_AXI4_ERR_EN
      ,
      .err_o  (err)
`endif
   );

   int checks = 0;
   int failures = 0;
   vec_t sb[$];

   // ---------------- AXI4 memory slave model ----------------
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
   logic [31:0] mem [0:63];
   int ar_wait, r_wait, aw_wait, w_wait, b_wait;
   logic r_pend, b_pend, aw_got, w_got;
   logic [31:0] r_data, aw_addr_s, w_data_s;
   logic [3:0]  w_strb_s;
   logic ld_en = 1'b0;
   logic [5:0] ld_idx = '0;
   logic [31:0] ld_val = '0;

   logic aw_hs, w_hs, wr_fire;
   logic [31:0] eff_addr, eff_data;
   logic [3:0]  eff_strb;

   assign axi.axi4_arready_i = axi.axi4_arvalid_o && (ar_wait >= ar_dly);
   assign axi.axi4_rvalid_i  = r_pend && (r_wait >= r_dly);
   assign axi.axi4_rdata_i   = r_data;
   assign axi.axi4_rresp_i   = rresp_cfg;
   assign axi.axi4_rid_i     = 4'd0;
   assign axi.axi4_rlast_i   = 1'b1;
   assign axi.axi4_awready_i = axi.axi4_awvalid_o && (aw_wait >= aw_dly);
   assign axi.axi4_wready_i  = axi.axi4_wvalid_o && (w_wait >= w_dly);
   assign axi.axi4_bvalid_i  = b_pend && (b_wait >= b_dly);
   assign axi.axi4_bresp_i   = bresp_cfg;
   assign axi.axi4_bid_i     = 4'd0;

   assign aw_hs    = axi.axi4_awvalid_o && axi.axi4_awready_i;
   assign w_hs     = axi.axi4_wvalid_o && axi.axi4_wready_i;
   assign wr_fire  = (aw_hs || aw_got) && (w_hs || w_got);
   assign eff_addr = aw_got ? aw_addr_s : axi.axi4_awaddr_o;
   assign eff_data = w_got ? w_data_s : axi.axi4_wdata_o;
   assign eff_strb = w_got ? w_strb_s : axi.axi4_wstrb_o;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_wait <= 0; r_wait <= 0; aw_wait <= 0; w_wait <= 0; b_wait <= 0;
         r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
         r_data <= '0; aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
      end else begin
         ar_wait <= (axi.axi4_arvalid_o && !axi.axi4_arready_i) ? ar_wait + 1 : 0;
         aw_wait <= (axi.axi4_awvalid_o && !axi.axi4_awready_i) ? aw_wait + 1 : 0;
         w_wait  <= (axi.axi4_wvalid_o && !axi.axi4_wready_i) ? w_wait + 1 : 0;
         if (axi.axi4_arvalid_o && axi.axi4_arready_i) begin
            r_pend <= 1'b1;
            r_wait <= 0;
            r_data <= mem[axi.axi4_araddr_o[7:2]];
         end else if (r_pend) begin
            if (axi.axi4_rvalid_i && axi.axi4_rready_o) r_pend <= 1'b0;
            else r_wait <= r_wait + 1;
         end
         if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= axi.axi4_awaddr_o; end
         if (w_hs) begin w_got <= 1'b1; w_data_s <= axi.axi4_wdata_o; w_strb_s <= axi.axi4_wstrb_o; end
         if (wr_fire) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_wait <= 0;
         end else if (b_pend) begin
            if (axi.axi4_bvalid_i && axi.axi4_bready_o) b_pend <= 1'b0;
            else b_wait <= b_wait + 1;
         end
      end
   end

   always @(posedge clk) begin
      if (ld_en) mem[ld_idx] <= ld_val;
      else if (rst_n && wr_fire)
         for (int i = 0; i < 4; i++)
            if (eff_strb[i]) mem[eff_addr[7:2]][8*i +: 8] <= eff_data[8*i +: 8];
   end

   // ---------------- bus monitor ----------------
   int ar_hi = 0, aw_hi = 0, w_hi = 0, viol = 0, order_viol = 0;
   logic [31:0] last_araddr = '0, last_awaddr = '0;
   logic [2:0]  last_arsize = '0, last_awsize = '0;
   logic [7:0]  last_arlen = '1, last_awlen = '1;
   logic [3:0]  last_wstrb = '0;
   logic        last_wlast = 1'b0;

   always @(posedge clk) begin
      if (axi.axi4_arvalid_o) ar_hi <= ar_hi + 1;
      if (axi.axi4_awvalid_o) aw_hi <= aw_hi + 1;
      if (axi.axi4_wvalid_o)  w_hi  <= w_hi + 1;
      if (pi1.pi1_rdy_o && (axi.axi4_arvalid_o || axi.axi4_awvalid_o || axi.axi4_wvalid_o ||
                            axi.axi4_rready_o || axi.axi4_bready_o))
         viol <= viol + 1;
      if (axi.axi4_awvalid_o && (axi.axi4_arvalid_o || axi.axi4_rready_o))
         order_viol <= order_viol + 1;
      if (axi.axi4_arvalid_o && axi.axi4_arready_i) begin
         last_araddr <= axi.axi4_araddr_o;
         last_arsize <= axi.axi4_arsize_o;
         last_arlen  <= axi.axi4_arlen_o;
      end
      if (aw_hs) begin
         last_awaddr <= axi.axi4_awaddr_o;
         last_awsize <= axi.axi4_awsize_o;
         last_awlen  <= axi.axi4_awlen_o;
      end
      if (w_hs) begin
         last_wstrb <= axi.axi4_wstrb_o;
         last_wlast <= axi.axi4_wlast_o;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      ld_en  = 1'b1;
      ld_idx = 6'(idx);
      ld_val = val;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   // Called at a negedge with the bridge idle; waits for completion then scores.
   task automatic issue(input int id, input vec_t v);
      int lat, ar0, aw0, w0;
      vec_t e;
      logic rd, wr;
      ar_dly = v.ar_dly; r_dly = v.r_dly; aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly;
      ar0 = ar_hi; aw0 = aw_hi; w0 = w_hi;
      sb.push_back(v);
      pi1.pi1_op_i   = v.op;
      pi1.pi1_addr_i = v.addr;
      pi1.pi1_data_i = v.data;
      pi1.pi1_sel_i  = v.sel;
      @(posedge clk);
      @(negedge clk);
      pi1.pi1_op_i = OP_NOP;
      chk($sformatf("v%0d_rdy_drop", id), pi1.pi1_rdy_o, 1'b0);
      lat = 1;
      while (pi1.pi1_rdy_o !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      e  = sb.pop_front();
      rd = (e.op == OP_READ) || (e.op == OP_SWAP);
      wr = (e.op == OP_WRITE) || (e.op == OP_SWAP);
      chk($sformatf("v%0d_latency", id), lat, e.exp_lat);
      chk($sformatf("v%0d_data", id), pi1.pi1_data_o, e.exp_data);
      chk($sformatf("v%0d_mem", id), mem[e.exp_axaddr[7:2]], e.exp_mem);
      chk($sformatf("v%0d_ar_cycles", id), ar_hi - ar0, rd ? e.ar_dly + 1 : 0);
      chk($sformatf("v%0d_aw_cycles", id), aw_hi - aw0, wr ? e.aw_dly + 1 : 0);
      chk($sformatf("v%0d_w_cycles", id), w_hi - w0, wr ? e.w_dly + 1 : 0);
      if (rd) begin
         chk($sformatf("v%0d_araddr", id), last_araddr, e.exp_axaddr);
         chk($sformatf("v%0d_arsize", id), last_arsize, 3'd2);
         chk($sformatf("v%0d_arlen", id), last_arlen, 8'd0);
      end
      if (wr) begin
         chk($sformatf("v%0d_awaddr", id), last_awaddr, e.exp_axaddr);
         chk($sformatf("v%0d_awsize_len", id), {last_awsize, last_awlen}, {3'd2, 8'd0});
         chk($sformatf("v%0d_wstrb_wlast", id), {last_wstrb, last_wlast}, {e.sel, 1'b1});
      end
   endtask

   vec_t vecs [0:7];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      pi1.pi1_op_i = OP_NOP;
      pi1.pi1_addr_i = '0;
      pi1.pi1_data_i = '0;
      pi1.pi1_sel_i = '0;
      poke(6'h03, 32'h0000_0000);
      poke(6'h10, 32'hDEAD_BEEF);
      poke(6'h08, 32'h1111_1111);
      poke(6'h11, 32'h7777_7777);
      @(negedge clk);
      chk("reset_rdy", pi1.pi1_rdy_o, 1'b1);
      chk("reset_data", pi1.pi1_data_o, 32'h0);
      chk("reset_valids", {axi.axi4_arvalid_o, axi.axi4_awvalid_o, axi.axi4_wvalid_o,
                           axi.axi4_rready_o, axi.axi4_bready_o}, 5'b0);
      chk("reset_holding_addr", axi.axi4_awaddr_o, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      //          op        addr    data           sel  ar r aw w b  exp_data       lat axaddr        mem
      vecs[0] = '{OP_READ,  30'h10, 32'h0,         4'h0, 0,0,0,0,0, 32'hDEADBEEF, 3, 32'h40, 32'hDEADBEEF};
      vecs[1] = '{OP_WRITE, 30'h03, 32'h12345678, 4'h6, 0,0,2,0,0, 32'hDEADBEEF, 5, 32'h0C, 32'h00345600};
      vecs[2] = '{OP_SWAP,  30'h08, 32'hA5A5A5A5, 4'hF, 0,0,0,0,0, 32'h11111111, 5, 32'h20, 32'hA5A5A5A5};
      vecs[3] = '{OP_READ,  30'h03, 32'h0,         4'h0, 0,0,0,0,0, 32'h00345600, 3, 32'h0C, 32'h00345600};
      vecs[4] = '{OP_WRITE, 30'h20, 32'hCAFEF00D, 4'hF, 0,0,0,3,2, 32'h00345600, 8, 32'h80, 32'hCAFEF00D};
      vecs[5] = '{OP_READ,  30'h20, 32'h0,         4'h0, 1,2,0,0,0, 32'hCAFEF00D, 6, 32'h80, 32'hCAFEF00D};
      vecs[6] = '{OP_WRITE, 30'h08, 32'h5A000000, 4'h8, 0,0,0,0,0, 32'hCAFEF00D, 3, 32'h20, 32'h5AA5A5A5};
      vecs[7] = '{OP_SWAP,  30'h11, 32'h0000BEEF, 4'h3, 0,1,1,0,1, 32'h77777777, 8, 32'h44, 32'h7777BEEF};
      for (int i = 0; i < 8; i++) issue(i, vecs[i]);

      // Back-to-back: WRITE is held on the bus while the READ finishes.
      ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
      pi1.pi1_op_i = OP_READ; pi1.pi1_addr_i = 30'h10;
      @(posedge clk); @(negedge clk);
      pi1.pi1_op_i = OP_WRITE; pi1.pi1_addr_i = 30'h04;
      pi1.pi1_data_i = 32'h0BADCAFE; pi1.pi1_sel_i = 4'hF;
      lat = 1;
      while (pi1.pi1_rdy_o !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      chk("b2b_read_lat", lat, 3);
      chk("b2b_read_data", pi1.pi1_data_o, 32'hDEADBEEF);
      @(negedge clk);
      chk("b2b_write_accepted", pi1.pi1_rdy_o, 1'b0);
      pi1.pi1_op_i = OP_NOP;
      lat = 1;
      while (pi1.pi1_rdy_o !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      chk("b2b_write_lat", lat, 3);
      chk("b2b_write_mem", mem[4], 32'h0BADCAFE);
      chk("b2b_data_held", pi1.pi1_data_o, 32'hDEADBEEF);

      // Asynchronous reset while AW and W are stalled.
      aw_dly = 10; w_dly = 10;
      pi1.pi1_op_i = OP_WRITE; pi1.pi1_addr_i = 30'h05; pi1.pi1_data_i = 32'h1; pi1.pi1_sel_i = 4'hF;
      @(posedge clk); @(negedge clk);
      pi1.pi1_op_i = OP_NOP;
      @(negedge clk);
      chk("rst_pre_valids", {axi.axi4_awvalid_o, axi.axi4_wvalid_o}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_valids", {axi.axi4_awvalid_o, axi.axi4_wvalid_o}, 2'b00);
      chk("rst_async_rdy", pi1.pi1_rdy_o, 1'b1);
      chk("rst_async_data", pi1.pi1_data_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      aw_dly = 0; w_dly = 0;
      @(negedge clk);
      chk("rst_idle", {pi1.pi1_rdy_o, axi.axi4_awvalid_o, axi.axi4_wvalid_o, axi.axi4_arvalid_o}, 4'b1000);
      issue(8, '{OP_READ, 30'h08, 32'h0, 4'h0, 0,0,0,0,0, 32'h5AA5A5A5, 3, 32'h20, 32'h5AA5A5A5});

`ifdef PI1_TO_AXI4_ERR_EN
      chk("err_idle", err, 1'b0);
      rresp_cfg = 2'b10;
      issue(9, '{OP_READ, 30'h10, 32'h0, 4'h0, 0,0,0,0,0, 32'hDEADBEEF, 3, 32'h40, 32'hDEADBEEF});
      chk("err_read_slverr", err, 1'b1);
      rresp_cfg = 2'b00;
      issue(10, '{OP_WRITE, 30'h06, 32'h1, 4'hF, 0,0,0,0,0, 32'hDEADBEEF, 3, 32'h18, 32'h1});
      chk("err_cleared", err, 1'b0);
      rresp_cfg = 2'b11;
      ar_dly = 0; r_dly = 0;
      pi1.pi1_op_i = OP_SWAP; pi1.pi1_addr_i = 30'h10; pi1.pi1_data_i = 32'h0; pi1.pi1_sel_i = 4'hF;
      @(posedge clk); @(negedge clk);
      pi1.pi1_op_i = OP_NOP;
      lat = 1;
      while (pi1.pi1_rdy_o !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      chk("err_swap_lat", lat, 3);
      chk("err_swap_nowrite", mem[16], 32'hDEADBEEF);
      chk("err_swap_flag", err, 1'b1);
      rresp_cfg = 2'b00;
      bresp_cfg = 2'b10;
      issue(11, '{OP_WRITE, 30'h07, 32'h2, 4'hF, 0,0,0,0,0, 32'hDEADBEEF, 3, 32'h1C, 32'h2});
      chk("err_write_slverr", err, 1'b1);
      bresp_cfg = 2'b00;
`endif

      @(negedge clk);
      chk("no_valid_while_rdy", viol, 0);
      chk("swap_read_before_write", order_viol, 0);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pi1_to_axi4.md
Name: pi1_to_axi4

Overview:
- PI1 slave to AXI4 master bridge. Accepts single-word PI1 read, write and swap ops and issues them as single-beat AXI4 transactions.
- Lets PI1 initiators (cores, DMA) reach AXI4-only memory and peripherals.
- One transaction outstanding at a time; a full FSM sequences the AW/W/B and AR/R channels.

Parameters:
- ARCHBITSZ, 32, data width in bits; legal values 16/32/64/128.
- AXI4_ID_WIDTH, 4, width of AXI4 ID fields.
- AXI4_ID, 0, constant value driven on awid/arid.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- pi1_op_i  in  2  00 NOP, 01 WRITE, 10 READ, 11 SWAP (read old value, then write).
- pi1_addr_i  in  ARCHBITSZ-clog2(ARCHBITSZ/8)  word address.
- pi1_data_i  in  ARCHBITSZ  write data.
- pi1_data_o  out  ARCHBITSZ  read data.
- pi1_sel_i  in  ARCHBITSZ/8  byte enables.
- pi1_rdy_o  out  1  bridge ready / result valid.
- AXI4 write address: axi4_awid_o, axi4_awaddr_o[ARCHBITSZ], axi4_awlen_o[8], axi4_awsize_o[3], axi4_awburst_o[2], axi4_awlock_o[1], axi4_awcache_o[4], axi4_awprot_o[3], axi4_awqos_o[4], axi4_awvalid_o (all out); axi4_awready_i (in).
- AXI4 write data: axi4_wdata_o, axi4_wstrb_o, axi4_wlast_o, axi4_wvalid_o (all out); axi4_wready_i (in).
- AXI4 write response: axi4_bready_o (out); axi4_bid_i, axi4_bresp_i[2], axi4_bvalid_i (in).
- AXI4 read address: axi4_arid_o, axi4_araddr_o, axi4_arlen_o, axi4_arsize_o, axi4_arburst_o, axi4_arlock_o, axi4_arcache_o, axi4_arprot_o, axi4_arqos_o, axi4_arvalid_o (all out); axi4_arready_i (in).
- AXI4 read data: axi4_rready_o (out); axi4_rid_i, axi4_rdata_i, axi4_rresp_i[2], axi4_rlast_i, axi4_rvalid_i (in).

Behaviour:
- Reset values: state IDLE; pi1_rdy_o=1; pi1_data_o=0; all *valid_o, bready_o, rready_o = 0; address/data holding registers = 0.
- Constant AXI fields:
  - len=0; size=clog2(ARCHBITSZ/8); burst=2'b01 INCR; lock=0; cache=4'b0011; prot=3'b000; qos=0; wlast=1; id=AXI4_ID.
  - awaddr/araddr = {held addr, clog2(ARCHBITSZ/8) zeros}.
  - wstrb = held sel; wdata = held data.
- Accept: in IDLE with pi1_rdy_o=1 and pi1_op_i!=00, register op/addr/data/sel. pi1_rdy_o drops the next cycle. NOP in IDLE: stay, rdy stays 1.
- States:
  - IDLE -> AR (READ, SWAP) or AW_W (WRITE).
  - AR: arvalid=1 until arready; then -> R.
  - R: rready=1 until rvalid; capture rdata into pi1_data_o; then -> AW_W if SWAP, else DONE.
  - AW_W: awvalid and wvalid both rise in the same cycle; each drops independently on its own ready. Once both handshakes have completed (either order or same cycle) -> B.
  - B: bready=1 until bvalid; then -> DONE.
  - DONE: pi1_rdy_o=1; -> IDLE, where a new op may be accepted in that same cycle.
- Valids are never withdrawn before their handshake.
- Minimum latency with zero-wait AXI slave: READ accept at cycle 0 -> pi1_rdy_o=1 with data at cycle 3; WRITE 3 cycles; SWAP 5 cycles.
- pi1_data_o holds its last read value across writes and NOPs.
- bid/rid/rlast are ignored. rresp/bresp are ignored unless the optional feature is compiled in.
- Reset asserted mid-transaction: immediate return to reset values. AXI slaves must be reset by the same rst_ni.

Optional Feature:
- Macro PI1_TO_AXI4_ERR_EN.
- With the macro, adds output err_o (1 bit), reset 0:
  - Set in DONE if any rresp/bresp captured in the transaction was SLVERR (10) or DECERR (11).
  - Cleared on the next accepted op.
  - A SWAP whose read returns an error skips the write phase and goes R -> DONE.
- Without the macro: no err_o port, responses ignored, SWAP always writes.

Test Plan:
- READ addr 0x10 (ARCHBITSZ=32), slave arready=1, rvalid one cycle after ar handshake with rdata 0xDEADBEEF -> araddr=0x40, arsize=2, arlen=0; pi1_rdy_o low 3 cycles then high with pi1_data_o=0xDEADBEEF.
- WRITE addr 0x3, data 0x12345678, sel 4'b0110; slave awready delayed 2 cycles, wready immediate -> awaddr=0xC, wstrb=0110, wvalid drops after 1 cycle, awvalid held 3 cycles, bready high until bvalid, then pi1_rdy_o=1.
- SWAP addr 0x8, data 0xA5A5A5A5, memory holds 0x11111111 -> AR/R completes before awvalid rises; pi1_data_o=0x11111111; memory then holds 0xA5A5A5A5.
- Back-to-back READ then WRITE with op presented continuously -> second op accepted in the DONE->IDLE cycle; no AXI valid asserted in IDLE.
- rst_ni pulsed low while awvalid=1 and awready=0 -> awvalid/wvalid 0 asynchronously, pi1_rdy_o=1 immediately, state IDLE.
- PI1_TO_AXI4_ERR_EN defined; READ returns rresp=2'b10 -> err_o=1 at DONE; next WRITE with bresp=00 -> err_o=0.
